// File: rtl/pixel_buf_pkg.sv
// Shared constants and writer FSM encoding for the frame-buffer pixel path.
package pixel_buf_pkg;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 16;
    localparam int PIX_W  = 8;

    localparam logic SRAM_RW_READ      = 1'b1;
    localparam logic SRAM_RW_WRITE     = 1'b0;
    localparam logic SRAM_START_ACTIVE = 1'b0;

    // SRAM issue FSM of the pixel writer; 2'b11 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10
    } wr_state_e;

endpackage

// File: rtl/pixel_word_fifo.sv
// Small synchronous word FIFO between the pixel packer and the SRAM issue FSM.
// Read/write pointers carry one extra wrap bit so full and empty are distinguishable.
module pixel_word_fifo
    import pixel_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop; both may happen in one cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    // Pointer registers; reset leaves the FIFO empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Packs a pixel stream into 16-bit words (even pixel low byte) and writes them
// to consecutive SRAM word addresses through the start/ready handshake.
module pixel_writer
    import pixel_buf_pkg::*;
#(
    parameter int               FIFO_DEPTH = 4,
    parameter logic [PIX_W-1:0] PAD_BYTE   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_data_out,
    output logic              sram_rw,
    output logic              sram_start,
    input  logic              sram_ready
);

    wr_state_e         state_q, state_d;
    logic [PIX_W-1:0]  half_reg_q, half_reg_d;
    logic              half_valid_q, half_valid_d;
    logic              flush_pending_q, flush_pending_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [WORD_W-1:0] sram_data_q, sram_data_d;
    logic              sram_start_q, sram_start_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_din, fifo_dout;
    logic              px_xfer, frame_load, drain_done;

    // Stall only when a full word is waiting on a full FIFO, or while draining.
    assign pixel_ready = ~(half_valid_q & fifo_full) & ~flush_pending_q;
    assign px_xfer     = pixel_valid & pixel_ready;
    assign busy        = half_valid_q | ~fifo_empty | (state_q != S_IDLE) | flush_pending_q;
    assign frame_load  = frame_start & ~busy;
    assign drain_done  = flush_pending_q & ~half_valid_q & fifo_empty & (state_q == S_IDLE);

    assign done          = drain_done;
    assign sram_addr     = sram_addr_q;
    assign sram_data_out = sram_data_q;
    assign sram_start    = sram_start_q;
    assign sram_rw       = SRAM_RW_WRITE;

    pixel_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Packer and flush control: pair pixels into words, pad an odd tail on flush.
    always_comb begin
        half_reg_d      = half_reg_q;
        half_valid_d    = half_valid_q;
        flush_pending_d = (flush_pending_q & ~drain_done) | flush;
        fifo_push       = 1'b0;
        fifo_din        = {pixel_in, half_reg_q};
        if (frame_load) begin
            half_valid_d = 1'b0;
        end
        // A pixel arriving with the flush pulse is packed before the flush acts.
        if (px_xfer) begin
            if (half_valid_q) begin
                fifo_push    = 1'b1;
                fifo_din     = {pixel_in, half_reg_q};
                half_valid_d = 1'b0;
            end else begin
                half_reg_d   = pixel_in;
                half_valid_d = 1'b1;
            end
        end else if (flush_pending_q && half_valid_q && !fifo_full) begin
            fifo_push    = 1'b1;
            fifo_din     = {PAD_BYTE, half_reg_q};
            half_valid_d = 1'b0;
        end
    end

    // SRAM issue FSM: present word, one-cycle start strobe, wait for ready.
    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        sram_addr_d  = sram_addr_q;
        sram_data_d  = sram_data_q;
        sram_start_d = sram_start_q;
        fifo_pop     = 1'b0;
        if (frame_load) begin
            addr_cnt_d = base_addr;
        end
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    sram_addr_d  = addr_cnt_q;
                    sram_data_d  = fifo_dout;
                    sram_start_d = SRAM_START_ACTIVE;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sram_start_d = ~SRAM_START_ACTIVE;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (sram_ready) begin
                    fifo_pop   = 1'b1;
                    addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                    state_d    = S_IDLE;
                end
            end
            default: begin
                sram_start_d = ~SRAM_START_ACTIVE;
                state_d      = S_IDLE;
            end
        endcase
    end

    // Control and SRAM interface registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            half_valid_q    <= 1'b0;
            flush_pending_q <= 1'b0;
            addr_cnt_q      <= '0;
            sram_addr_q     <= '0;
            sram_data_q     <= '0;
            sram_start_q    <= ~SRAM_START_ACTIVE;
        end else begin
            state_q         <= state_d;
            half_valid_q    <= half_valid_d;
            flush_pending_q <= flush_pending_d;
            addr_cnt_q      <= addr_cnt_d;
            sram_addr_q     <= sram_addr_d;
            sram_data_q     <= sram_data_d;
            sram_start_q    <= sram_start_d;
        end
    end

    // Held pixel byte; only meaningful while half_valid_q is set.
    always_ff @(posedge clk) begin
        half_reg_q <= half_reg_d;
    end

endmodule

// File: tb/tb_pixel_writer.sv
`timescale 1ns/1ps
module tb_pixel_writer;
    import pixel_buf_pkg::*;

    localparam int         D   = 4;
    localparam logic [7:0] PAD = 8'h00;

    logic        clk = 1'b0;
    logic        reset, frame_start, pixel_valid, flush, sram_ready;
    logic [15:0] base_addr;
    logic [7:0]  pixel_in;
    logic        pixel_ready, busy, done, sram_rw, sram_start;
    logic [15:0] sram_addr, sram_data_out;

    pixel_writer #(.FIFO_DEPTH(D), .PAD_BYTE(PAD)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .base_addr(base_addr),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .flush(flush), .busy(busy), .done(done), .sram_addr(sram_addr),
        .sram_data_out(sram_data_out), .sram_rw(sram_rw), .sram_start(sram_start),
        .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_pop_cyc = -1;
    int resp_lat = 2;
    int resp_cnt = -1;
    bit hold_ready = 1'b0;
    logic [15:0] cap_addr, cap_data;
    logic [15:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
    logic [7:0]  m_pix[$];
    logic [15:0] m_base;

    // SRAM responder: captures each write at the start strobe, checks the bus
    // stays stable, answers with a one-cycle ready resp_lat cycles later.
    initial begin
        sram_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!reset) begin
                sram_ready = 1'b0;
                resp_cnt = -1;
            end else begin
                total++;
                if (sram_rw !== 1'b0) begin bad++; $display("FAIL sram_rw: got %b want 0", sram_rw); end
                if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
                if (sram_ready) begin
                    last_pop_cyc = cyc;
                    sram_ready = 1'b0;
                    resp_cnt = -1;
                end else if (resp_cnt < 0) begin
                    if (sram_start === 1'b0) begin
                        cap_addr = sram_addr;
                        cap_data = sram_data_out;
                        got_addr.push_back(sram_addr);
                        got_data.push_back(sram_data_out);
                        resp_cnt = resp_lat;
                    end
                end else begin
                    total++;
                    if (sram_addr !== cap_addr || sram_data_out !== cap_data || sram_start !== 1'b1) begin
                        bad++;
                        $display("FAIL bus_stable: got %h@%h start=%b want %h@%h start=1",
                                 sram_data_out, sram_addr, sram_start, cap_data, cap_addr);
                    end
                    if (resp_cnt > 0) resp_cnt--;
                    if (resp_cnt == 0 && !hold_ready) sram_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_sb();
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
        m_pix.delete();
        done_cnt = 0;
    endtask

    // Reference model: word i holds pixels 2i (low) and 2i+1 (high) at base+i.
    task automatic build_expected();
        int nw = (m_pix.size() + 1) / 2;
        for (int i = 0; i < nw; i++) begin
            logic [7:0] lo = m_pix[2*i];
            logic [7:0] hi = (2*i + 1 < m_pix.size()) ? m_pix[2*i+1] : PAD;
            exp_addr.push_back(m_base + 16'(i));
            exp_data.push_back({hi, lo});
        end
    endtask

    task automatic pulse_frame(input logic [15:0] b);
        base_addr = b; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] p, input bit with_flush);
        bit acc = 1'b0;
        pixel_in = p; pixel_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk); acc = pixel_ready;
            flush = with_flush & acc;
            @(posedge clk); #1;
        end
        pixel_valid = 1'b0; flush = 1'b0;
        total++;
        if (acc) m_pix.push_back(p);
        else begin bad++; $display("FAIL pixel_accept: pixel %h not accepted, want accepted", p); end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin @(posedge clk); #1; n++; end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_wait: busy=%b after %0d cycles, want 0", busy, n); end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        total += 6;
        if (pixel_ready !== 1'b1) begin bad++; $display("FAIL rst_pixel_ready: got %b want 1", pixel_ready); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        if (sram_addr !== 16'h0) begin bad++; $display("FAIL rst_addr: got %h want 0000", sram_addr); end
        if (sram_data_out !== 16'h0) begin bad++; $display("FAIL rst_data: got %h want 0000", sram_data_out); end
        if (sram_start !== 1'b1) begin bad++; $display("FAIL rst_start: got %b want 1", sram_start); end
        reset = 1'b1;
        @(posedge clk); #1;
        total += 2;
        if (sram_start !== 1'b1) begin bad++; $display("FAIL post_rst_start: got %b want 1", sram_start); end
        if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [7:0] px[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_sb();
        m_base = 16'h0100;
        pulse_frame(16'h0100);
        foreach (px[i]) send_pixel(px[i], 1'b0);
        wait_idle(200);
        build_expected();
        total++;
        if (got_addr.size() != exp_addr.size()) begin bad++; $display("FAIL basic_count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                bad++; $display("FAIL basic_word%0d: got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
            end
        end
        total++;
        if (done_cnt != 0) begin bad++; $display("FAIL basic_done: got %0d pulses want 0", done_cnt); end
    endtask

    task automatic test_flush_odd();
        logic [7:0] px[3] = '{8'hA1, 8'hB2, 8'hC3};
        clear_sb();
        m_base = 16'h0200;
        pulse_frame(16'h0200);
        foreach (px[i]) send_pixel(px[i], 1'b0);
        pulse_flush();
        wait_idle(200);
        build_expected();
        total++;
        if (got_addr.size() != exp_addr.size()) begin bad++; $display("FAIL odd_count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                bad++; $display("FAIL odd_word%0d: got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
            end
        end
        total += 2;
        if (done_cnt != 1) begin bad++; $display("FAIL odd_done_count: got %0d want 1", done_cnt); end
        // done is seen in the cycle right after the edge that popped the last word
        if (done_cyc != last_pop_cyc) begin bad++; $display("FAIL odd_done_time: got cycle %0d want %0d", done_cyc, last_pop_cyc); end
    endtask

    task automatic test_backpressure();
        logic [7:0] v;
        clear_sb();
        m_base = 16'($urandom);
        pulse_frame(m_base);
        hold_ready = 1'b1;
        for (int i = 0; i < 2*D + 1; i++) send_pixel(8'($urandom), 1'b0);
        total += 2;
        if (pixel_ready !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", pixel_ready); end
        if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy: got %b want 1", busy); end
        v = 8'($urandom);
        pixel_in = v; pixel_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            total++;
            if (pixel_ready !== 1'b0) begin bad++; $display("FAIL bp_stall: got ready %b want 0", pixel_ready); end
        end
        hold_ready = 1'b0;
        send_pixel(v, 1'b0);
        for (int i = 0; i < 3; i++) send_pixel(8'($urandom), 1'b0);
        pulse_flush();
        wait_idle(400);
        build_expected();
        total++;
        if (got_addr.size() != exp_addr.size()) begin bad++; $display("FAIL bp_count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                bad++; $display("FAIL bp_word%0d: got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
            end
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        clear_sb();
        m_base = 16'hFFFF;
        pulse_frame(16'hFFFF);
        for (int i = 0; i < 4; i++) send_pixel(8'($urandom), 1'b0);
        wait_idle(200);
        build_expected();
        total++;
        if (got_addr.size() != exp_addr.size()) begin bad++; $display("FAIL wrap_count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                bad++; $display("FAIL wrap_word%0d: got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_sb();
        hold_ready = 1'b1;
        pulse_frame(16'h0300);
        send_pixel(8'h5A, 1'b0);
        send_pixel(8'hA5, 1'b0);
        while (got_addr.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
        total++;
        if (got_addr.size() == 0) begin bad++; $display("FAIL rmid_issue: got no start strobe, want one"); end
        repeat (2) begin @(posedge clk); #1; end
        #3 reset = 1'b0;
        #1;
        total += 4;
        if (sram_start !== 1'b1) begin bad++; $display("FAIL rmid_start: got %b want 1", sram_start); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        if (pixel_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", pixel_ready); end
        if (done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", done); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        hold_ready = 1'b0;
        clear_sb();
        @(posedge clk); #1;
        m_base = 16'h0400;
        pulse_frame(16'h0400);
        for (int i = 0; i < 4; i++) send_pixel(8'($urandom), 1'b0);
        wait_idle(200);
        build_expected();
        total++;
        if (got_addr.size() != exp_addr.size()) begin bad++; $display("FAIL rmid_count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                bad++; $display("FAIL rmid_word%0d: got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_busy_frame_start();
        clear_sb();
        m_base = 16'h0500;
        pulse_frame(16'h0500);
        hold_ready = 1'b1;
        send_pixel(8'($urandom), 1'b0);
        send_pixel(8'($urandom), 1'b0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL bfs_busy: got %b want 1", busy); end
        pulse_frame(16'h0A00);
        hold_ready = 1'b0;
        send_pixel(8'($urandom), 1'b0);
        send_pixel(8'($urandom), 1'b0);
        pulse_flush();
        wait_idle(200);
        build_expected();
        total++;
        if (got_addr.size() != exp_addr.size()) begin bad++; $display("FAIL bfs_count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                bad++; $display("FAIL bfs_word%0d: got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_same_cycle_flush();
        clear_sb();
        m_base = 16'h0600;
        pulse_frame(16'h0600);
        send_pixel(8'($urandom), 1'b0);
        send_pixel(8'($urandom), 1'b1);
        wait_idle(200);
        build_expected();
        total++;
        if (got_addr.size() != exp_addr.size()) begin bad++; $display("FAIL scf_count: got %0d want %0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            total++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                bad++; $display("FAIL scf_word%0d: got %h@%h want %h@%h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
            end
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL scf_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_empty_flush();
        clear_sb();
        pulse_flush();
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL eflush_done: got %b want 1", done); end
        @(posedge clk); #1;
        total += 3;
        if (done !== 1'b0) begin bad++; $display("FAIL eflush_done_clear: got %b want 0", done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL eflush_busy: got %b want 0", busy); end
        if (got_addr.size() != 0) begin bad++; $display("FAIL eflush_writes: got %0d want 0", got_addr.size()); end
    endtask

    initial begin
        reset = 1'b0; frame_start = 1'b0; base_addr = '0;
        pixel_in = '0; pixel_valid = 1'b0; flush = 1'b0;
        test_reset();
        test_basic();
        test_flush_odd();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_busy_frame_start();
        test_same_cycle_flush();
        test_empty_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Upstream counterpart of the frame-buffer pixel reader.
- Accepts a sequential stream of 8-bit pixels and packs pixel pairs into 16-bit words. The even pixel goes to [7:0] and the odd pixel to [15:8], which is the layout the reader expects.
- Writes each word to the shared SRAM controller through the start/ready handshake at consecutive word addresses.
- A small word FIFO decouples pixel arrival from SRAM latency.

Parameters:
- FIFO_DEPTH, 4, number of 16-bit words buffered between the packer and the SRAM issue FSM; power of 2, at least 2.
- PAD_BYTE, 8'h00, upper byte written when a flush completes an odd-length stream.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; loads base_addr and clears packer state
- base_addr  in  16  first SRAM word address of the frame
- pixel_in  in  8  pixel data
- pixel_valid  in  1  pixel_in is valid
- pixel_ready  out  1  block can accept a pixel this cycle
- flush  in  1  one-cycle pulse; write out any partial word, then drain
- busy  out  1  packer, FIFO or SRAM transaction non-empty/active
- done  out  1  one-cycle pulse when a flush has fully drained
- sram_addr  out  16  word address to SRAM
- sram_data_out  out  16  write data to SRAM
- sram_rw  out  1  constant 0 (write)
- sram_start  out  1  active-low transaction start
- sram_ready  in  1  SRAM transaction complete

Behaviour:
- Reset (async, active-low):
  - pixel_ready=1, busy=0, done=0, sram_addr=0, sram_data_out=0, sram_start=1.
  - FIFO emptied, half-word register empty, address counter=0, FSM=S_IDLE, flush_pending=0.
  - Reset mid-transaction abandons the transaction: sram_start returns to 1 immediately and no retry occurs.
- Pixel transfer: a pixel is transferred when pixel_valid & pixel_ready is high at a clk edge.
- Packer:
  - If half_valid=0: half_reg<=pixel_in, half_valid<=1.
  - Else: push {pixel_in, half_reg} into the FIFO and set half_valid<=0.
- pixel_ready = ~(half_valid & fifo_full) & ~flush_pending. It uses registered FIFO state; there is no same-cycle pass-through from a pop.
- Flush:
  - flush sets flush_pending.
  - If half_valid=1, {PAD_BYTE, half_reg} is pushed once the FIFO is not full.
  - When the FIFO is empty and the FSM is in S_IDLE with nothing pending: done pulses for 1 cycle and flush_pending clears.
  - A flush with nothing buffered gives done on the next cycle.
  - If a pixel transfer and flush occur in the same cycle, the pixel is packed first and the flush applies to the resulting state.
- frame_start:
  - Honoured only when busy=0. It loads the address counter with base_addr and clears half_valid.
  - When busy=1 it is ignored.
- SRAM FSM (addr/data stable from S_ISSUE until the transaction completes):
  - S_IDLE: if the FIFO is non-empty, drive sram_addr<=addr_cnt, sram_data_out<=FIFO head, sram_start<=0, then go to S_ISSUE.
  - S_ISSUE: exactly 1 cycle; sram_start<=1, then go to S_WAIT.
  - S_WAIT: on the first cycle sram_ready=1, pop the FIFO, addr_cnt<=addr_cnt+1 (16-bit wrap, 16'hFFFF to 16'h0000), then go to S_IDLE.
  - Minimum cost is 3 cycles per word. Back-to-back words restart from S_IDLE.
  - sram_ready is ignored outside S_WAIT.
  - The FIFO push and pop may occur in the same cycle; occupancy is then unchanged.
- busy = half_valid | ~fifo_empty | (state!=S_IDLE) | flush_pending.
- Illegal state: go to S_IDLE with sram_start=1.

Decomposition:
- Shared package pixel_buf_pkg:
  - SRAM_RW_READ=1'b1, SRAM_RW_WRITE=1'b0, SRAM_START_ACTIVE=1'b0.
  - ADDR_W=16, WORD_W=16, PIX_W=8.
  - Writer FSM state encodings.
- Sub-module pixel_word_fifo:
  - Synchronous FIFO with parameter DEPTH and ports push, pop, din, dout, full, empty.
  - Pointer-based with an extra wrap bit; resets to empty.

Test Plan:
- frame_start with base_addr=16'h0100, then pixels 8'h11, 8'h22, 8'h33, 8'h44 with sram_ready returned 2 cycles after each start -> writes 16'h2211@0x0100 and 16'h4433@0x0101, sram_rw=0 throughout, then busy=0.
- 3 pixels (8'hA1, 8'hB2, 8'hC3) then flush, PAD_BYTE=8'h00 -> writes 16'hB2A1 then 16'h00C3; done pulses once, 1 cycle after the last pop.
- sram_ready held 0 while streaming 2*FIFO_DEPTH+1 pixels -> pixel_ready falls when half_valid=1 and the FIFO is full; no pixel is lost; all words are written in order after sram_ready is released.
- base_addr=16'hFFFF with 4 pixels -> second word is written to 16'h0000.
- reset asserted during S_WAIT -> sram_start=1, busy=0, pixel_ready=1 immediately (async); after release a new frame_start writes correctly.
- frame_start pulsed while busy=1 -> address unchanged and the stream continues at the old addresses. Separately, pixel transfer and flush in the same cycle on an even count -> the pair is written with no pad word.
